// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write arbiter.
//   arb_state_e : arbiter FSM state (IDLE arbitrates, BURST transfers beats)
//   len_width() : bit width of a burst-length field able to hold 0..burst_max
//   idx_width() : bit width of a requester index (at least one bit)
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    function automatic int len_width(input int burst_max);
        return $clog2(burst_max + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req_vec  : request vector, one bit per requester
//   last_idx : index of the previous winner; search starts one past it
//   pick     : one-hot vector of the first requester found (all zero if none)
//   any      : high when at least one request is present
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req_vec,
    input  logic [IDX_W-1:0] last_idx,
    output logic [N-1:0]     pick,
    output logic             any
);

    always_comb begin
        int idx;
        pick = '0;
        idx  = 0;
        any  = |req_vec;
        // Walk from farthest to nearest so the requester closest after
        // last_idx is the one left standing.
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_idx) + k) % N;
            if (req_vec[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst write arbiter in front of a FIFO.
// Requesters ask for a burst of req_len words; the round-robin candidate is
// granted only when the tracked free space covers its whole burst, so the
// granted requester can stream beats without ever hitting a full FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   req, req_len      : burst requests and their lengths (flattened)
//   req_valid/req_data: per-requester beat valid and data (flattened)
//   gnt, data_ack     : registered one-hot grant, per-beat acceptance
//   fifo_wr_en/_data  : FIFO write port
//   fifo_rd_en, fifo_empty, fifo_full : FIFO consumer side, observed only
//   occupancy, busy   : tracked word count, high while a burst is active
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int DEPTH      = 10,
    parameter  int BURST_MAX  = 4,
    localparam int LEN_W      = len_width(BURST_MAX),
    localparam int OCC_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*LEN_W-1:0]      req_len,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            data_ack,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_rd_en,
    input  logic                          fifo_empty,
    input  logic                          fifo_full,
    output logic [OCC_W-1:0]              occupancy,
    output logic                          busy
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [OCC_W-1:0]   occ_q, occ_d;

    logic [NUM_REQ-1:0] pick;
    logic               pick_any;
    logic [IDX_W-1:0]   cand_idx;
    logic [LEN_W-1:0]   cand_len;
    logic [LEN_W-1:0]   cand_eff;
    logic [OCC_W-1:0]   free_words;
    logic               space_ok;
    logic               wr_ok;
    logic               rd_ok;

    rr_picker #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .req_vec  (req),
        .last_idx (last_q),
        .pick     (pick),
        .any      (pick_any)
    );

    // Index and requested length of the picked requester.
    always_comb begin
        cand_idx = '0;
        cand_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) begin
                cand_idx = IDX_W'(i);
                cand_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // A zero length still moves one word; oversize requests are clipped.
    always_comb begin
        cand_eff = cand_len;
        if (cand_len == '0) begin
            cand_eff = LEN_W'(1);
        end else if (cand_len > LEN_W'(BURST_MAX)) begin
            cand_eff = LEN_W'(BURST_MAX);
        end
    end

    assign free_words = OCC_W'(DEPTH) - occ_q;
    // The picked requester blocks others until its whole burst fits, so a
    // long burst cannot be starved by a stream of short ones. A FIFO that
    // reports itself full never starts a burst, whatever the count says.
    assign space_ok   = (32'(free_words) >= 32'(cand_eff)) && !fifo_full;

    // Beat acceptance is purely combinational on the registered grant.
    assign data_ack   = rst ? '0 : (gnt_q & req_valid);
    assign fifo_wr_en = |data_ack;
    assign gnt        = gnt_q;
    assign busy       = (state_q == BURST);
    assign occupancy  = occ_q;

    logic [DATA_WIDTH-1:0] masked_data [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_mask
        assign masked_data[gi] = data_ack[gi] ? req_data[gi*DATA_WIDTH +: DATA_WIDTH]
                                              : '0;
    end

    always_comb begin
        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            fifo_wr_data = fifo_wr_data | masked_data[i];
        end
    end

    // Occupancy: a simultaneous write and read cancel out; both ends clamp.
    assign wr_ok = fifo_wr_en && (occ_q != OCC_W'(DEPTH));
    assign rd_ok = fifo_rd_en && !fifo_empty && (occ_q != '0);

    always_comb begin
        occ_d = occ_q;
        if (wr_ok && !rd_ok) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (rd_ok && !wr_ok) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        last_d     = last_q;
        if (state_q == IDLE) begin
            gnt_d = '0;
            if (pick_any && space_ok) begin
                state_d    = BURST;
                gnt_d      = pick;
                beat_cnt_d = cand_eff;
                last_d     = cand_idx;
            end
        end else begin
            if (fifo_wr_en) begin
                beat_cnt_d = beat_cnt_q - LEN_W'(1);
                if (beat_cnt_q == LEN_W'(1)) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            beat_cnt_q <= '0;
            last_q     <= IDX_W'(NUM_REQ - 1);
            occ_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
            last_q     <= last_d;
            occ_q      <= occ_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int DEPTH      = 10;
    localparam int BURST_MAX  = 4;
    localparam int LEN_W      = 3;
    localparam int OCC_W      = 4;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*LEN_W-1:0]      req_len;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            data_ack;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic                          fifo_rd_en;
    logic                          fifo_empty;
    logic                          fifo_full;
    logic [OCC_W-1:0]              occupancy;
    logic                          busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .BURST_MAX  (BURST_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_len      (req_len),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .gnt          (gnt),
        .data_ack     (data_ack),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .occupancy    (occupancy),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream FIFO: only its word count and flags.
    int fifo_cnt;
    always @(posedge clk) begin
        if (rst) begin
            fifo_cnt <= 0;
        end else begin
            fifo_cnt <= fifo_cnt + (fifo_wr_en ? 1 : 0) - ((fifo_rd_en && fifo_cnt > 0) ? 1 : 0);
        end
    end
    assign fifo_full  = (fifo_cnt >= DEPTH);
    assign fifo_empty = (fifo_cnt == 0);

    typedef struct {
        int         idx;
        logic [7:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    wr_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int idx, input int data);
        beat_t b;
        b.idx  = idx;
        b.data = 8'(data);
        exp_q.push_back(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int i, input int v);
        req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic set_data(input int i, input int v);
        req_data[i*DATA_WIDTH +: DATA_WIDTH] = 8'(v);
    endtask

    // Wait (bounded) until the monitor has seen 'target' writes, then
    // return just after the next rising edge.
    task automatic wait_wr(input int target, input string name);
        int n = 0;
        while (wr_seen < target && n < 60) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, wr_seen, target);
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for gnt[i]; returns at the falling edge where it is seen.
    task automatic wait_gnt(input int i, input string name);
        int n = 0;
        int found = 0;
        while (found == 0 && n < 60) begin
            @(negedge clk);
            found = gnt[i] ? 1 : 0;
            n++;
        end
        chk(name, found, 1);
    endtask

    // Monitor / scoreboard: every accepted beat is popped and compared.
    int    mon_idx;
    beat_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            chk("idle_quiet", (!busy && (gnt != '0 || fifo_wr_en)) ? 1 : 0, 0);
            if (fifo_wr_en) begin
                chk("no_write_when_full", fifo_full ? 1 : 0, 0);
                chk("ack_onehot", $onehot(data_ack) ? 1 : 0, 1);
                mon_idx = -1;
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (data_ack[i]) mon_idx = i;
                end
                $display("write: requester %0d data %02h occupancy %0d", mon_idx, fifo_wr_data, occupancy);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: requester %0d data %02h, expected no write", mon_idx, fifo_wr_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("wr_requester", mon_idx, mon_e.idx);
                    chk("wr_data", int'(fifo_wr_data), int'(mon_e.data));
                end
                wr_seen++;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        rst        = 1'b1;
        req        = '0;
        req_len    = '0;
        req_valid  = '0;
        req_data   = '0;
        fifo_rd_en = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_occ", int'(occupancy), 0);
        chk("rst_wr_en", int'(fifo_wr_en), 0);
        chk("rst_ack", int'(data_ack), 0);
        chk("rst_wr_data", int'(fifo_wr_data), 0);
        tick();
        rst = 1'b0;

        // All four requesting single beats: order 0,1,2,3,0.
        for (int i = 0; i < NUM_REQ; i++) begin
            set_len(i, 1);
            set_data(i, 'hA0 + i);
        end
        push(0, 'hA0); push(1, 'hA1); push(2, 'hA2); push(3, 'hA3); push(0, 'hA0);
        req       = 4'b1111;
        req_valid = 4'b1111;
        wait_wr(5, "t1_writes");
        req       = '0;
        req_valid = '0;
        @(negedge clk);
        chk("t1_occ", int'(occupancy), 5);
        chk("t1_gnt_idle", int'(gnt), 0);
        repeat (3) tick();
        chk("t1_total_writes", wr_seen, 5);

        // Requester 2, len 4, valid 1,0,1,1,1; a read lands on the first beat.
        set_len(2, 4);
        set_data(2, 'h21);
        push(2, 'h21); push(2, 'h22); push(2, 'h23); push(2, 'h24);
        req_valid = 4'b0100;
        req       = 4'b0100;
        wait_gnt(2, "t2_gnt");
        chk("t2_occ_before", int'(occupancy), 5);
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0;
        req        = '0;
        req_valid  = '0;
        set_data(2, 'h22);
        @(negedge clk);
        chk("t2_simul_wr_rd_occ", int'(occupancy), 5);
        chk("t2_bubble_ack", int'(data_ack), 0);
        chk("t2_gnt_hold", int'(gnt), 4);
        tick();
        req_valid = 4'b0100;
        tick();
        set_data(2, 'h23);
        tick();
        set_data(2, 'h24);
        @(negedge clk);
        chk("t2_last_beat_gnt", int'(gnt), 4);
        chk("t2_last_beat_ack", int'(data_ack), 4);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t2_gnt_fall", int'(gnt), 0);
        chk("t2_busy_fall", int'(busy), 0);
        chk("t2_occ_after", int'(occupancy), 8);

        // Occupancy 8, requester 1 wants 3: wait, then one read frees space.
        tick();
        set_len(1, 3);
        set_data(1, 'h31);
        push(1, 'h31); push(1, 'h31); push(1, 'h31);
        req_valid = 4'b0010;
        req       = 4'b0010;
        repeat (4) begin
            @(negedge clk);
            chk("t3_no_gnt", int'(gnt), 0);
        end
        tick();
        fifo_rd_en = 1'b1;
        tick();
        fifo_rd_en = 1'b0;
        @(negedge clk);
        chk("t3_occ_after_read", int'(occupancy), 7);
        chk("t3_gnt_not_yet", int'(gnt), 0);
        tick();
        req = '0;
        @(negedge clk);
        chk("t3_gnt_after_read", int'(gnt), 2);
        wait_wr(12, "t3_writes");
        req_valid = '0;
        @(negedge clk);
        chk("t3_occ_full", int'(occupancy), 10);
        chk("t3_fifo_full", int'(fifo_full), 1);
        set_len(0, 1);
        set_data(0, 'h55);
        req_valid = 4'b0001;
        req       = 4'b0001;
        repeat (4) begin
            @(negedge clk);
            chk("t3_full_no_gnt", int'(gnt), 0);
        end
        req       = '0;
        req_valid = '0;

        // Reset during the second beat of a len-4 burst.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_len(3, 4);
        set_data(3, 'h41);
        push(3, 'h41);
        req_valid = 4'b1000;
        req       = 4'b1000;
        wait_gnt(3, "t4_gnt3");
        tick();
        rst = 1'b1;
        set_len(0, 1);
        set_data(0, 'h50);
        req_valid = 4'b1001;
        req       = 4'b1001;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_gnt_after_rst", int'(gnt), 0);
        chk("t4_occ_after_rst", int'(occupancy), 0);
        chk("t4_busy_after_rst", int'(busy), 0);
        base = wr_seen;
        push(0, 'h50);
        push(3, 'h41); push(3, 'h41); push(3, 'h41); push(3, 'h41);
        tick();
        req = 4'b1000;
        @(negedge clk);
        chk("t4_gnt0_first", int'(gnt), 1);
        wait_wr(base + 5, "t4_writes");
        req       = '0;
        req_valid = '0;
        @(negedge clk);
        chk("t4_occ", int'(occupancy), 5);

        // Length 0 moves one word; length 7 is clipped to 4.
        tick();
        set_len(1, 0);
        set_data(1, 'h61);
        push(1, 'h61);
        base      = wr_seen;
        req_valid = 4'b0010;
        req       = 4'b0010;
        wait_wr(base + 1, "t5_len0_write");
        req       = '0;
        req_valid = '0;
        repeat (3) tick();
        chk("t5_len0_single", wr_seen, base + 1);
        set_len(2, 7);
        set_data(2, 'h62);
        push(2, 'h62); push(2, 'h62); push(2, 'h62); push(2, 'h62);
        req_valid = 4'b0100;
        req       = 4'b0100;
        wait_gnt(2, "t5_gnt2");
        req = '0;
        cnt = 0;
        while (gnt[2] && cnt < 10) begin
            cnt++;
            @(negedge clk);
        end
        chk("t5_len7_beats", cnt, 4);
        chk("t5_occ", int'(occupancy), 10);
        req_valid = '0;
        repeat (2) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of write requesters.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, FIFO word width.
REQ-003 SHALL have parameter DEPTH, default 10, FIFO depth in words; any value >=2, not restricted to a power of two.
REQ-004 SHALL have parameter BURST_MAX, default 4, maximum burst length in words; LEN_W = $clog2(BURST_MAX+1).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-007 Port: rst  in  1  synchronous active-high reset.
REQ-008 Port: req  in  NUM_REQ  per-requester burst request, held until granted.
REQ-009 Port: req_len  in  NUM_REQ*LEN_W  flattened burst length per requester, stable while req is high.
REQ-010 Port: req_valid  in  NUM_REQ  per-requester data beat valid.
REQ-011 Port: req_data  in  NUM_REQ*DATA_WIDTH  flattened beat data per requester.
REQ-012 Port: gnt  out  NUM_REQ  one-hot grant, registered.
REQ-013 Port: data_ack  out  NUM_REQ  beat accepted this cycle.
REQ-014 Port: fifo_wr_en  out  1  write strobe to the FIFO.
REQ-015 Port: fifo_wr_data  out  DATA_WIDTH  write data to the FIFO.
REQ-016 Port: fifo_rd_en  in  1  FIFO consumer read strobe, monitored only.
REQ-017 Port: fifo_empty, fifo_full  in  1 each  FIFO flags, monitored only.
REQ-018 Port: occupancy  out  $clog2(DEPTH+1)  tracked FIFO word count.
REQ-019 Port: busy  out  1  high while in BURST.

Function
REQ-020 FSM SHALL have two states: IDLE (arbitrate) and BURST (transfer for the granted requester).
REQ-021 In IDLE, the candidate SHALL be the first requester with req high, searching round-robin from last_winner+1.
REQ-022 The candidate SHALL win only if DEPTH-occupancy >= its effective length; otherwise the arbiter waits without skipping it (no starvation of long bursts).
REQ-023 Effective length SHALL be req_len, with 0 treated as 1 and values >BURST_MAX treated as BURST_MAX.
REQ-024 On a win in cycle N, gnt SHALL be one-hot from cycle N+1, the beat counter SHALL load the effective length, last_winner SHALL update, and the state SHALL become BURST.
REQ-025 In BURST, data_ack[i] = fifo_wr_en = gnt[i] & req_valid[i] combinationally, with fifo_wr_data = req_data slice i; valid low inserts bubbles without penalty.
REQ-026 The beat counter SHALL decrement per accepted beat; the final beat's cycle M returns the FSM to IDLE, gnt falls at M+1, and the next grant is at M+2 at the earliest.
REQ-027 occupancy SHALL be +1 on fifo_wr_en, -1 on fifo_rd_en & !fifo_empty, and unchanged when both occur; it never exceeds DEPTH or falls below 0.
REQ-028 Space reservation (REQ-022) SHALL guarantee that fifo_wr_en is never asserted while fifo_full is high.
REQ-029 gnt, fifo_wr_en and data_ack SHALL never assert in IDLE.
REQ-030 req deasserting mid-burst SHALL be ignored; the burst completes on valid beats.

Reset
REQ-031 On rst: state=IDLE, gnt=0, data_ack=0, fifo_wr_en=0, fifo_wr_data=0, occupancy=0, busy=0, beat counter=0, last_winner=NUM_REQ-1 (requester 0 highest priority).
REQ-032 Reset mid-burst SHALL abort the burst, with gnt low in the cycle after the rst edge; the FIFO is reset on the same rst.

Structure
REQ-033 Shared package fifo_arb_pkg SHALL hold the state enum (IDLE, BURST) and the LEN_W width helper function.
REQ-034 Round-robin selection SHALL be a combinational sub-module rr_picker (inputs: request vector, last_winner; outputs: one-hot pick, any).

Verification (NUM_REQ=4, DEPTH=10, BURST_MAX=4)
REQ-035 After reset, req=4'b1111 with all len=1 and valid high -> grant order 0,1,2,3,0; each grant is 1 beat; occupancy reaches 5.
REQ-036 Requester 2, len=4, valid pattern 1,0,1,1,1 -> 4 writes over 5 cycles in order; gnt falls the cycle after the 4th ack.
REQ-037 occupancy=8 with no reads and requester 1 at len=3 -> no grant; one fifo_rd_en pulse -> occupancy 7 -> gnt[1] the next cycle.
REQ-038 Simultaneous fifo_wr_en and fifo_rd_en at occupancy 5 -> occupancy stays 5; fill to 10 -> fifo_full high and fifo_wr_en never high while full.
REQ-039 rst pulsed during the 2nd beat of a len=4 burst -> the following cycle has gnt=0, occupancy=0, busy=0; the next grant goes to requester 0 if it is requesting.
REQ-040 req_len=0 -> single beat; req_len=7 (>BURST_MAX) -> exactly 4 beats.
